// File: rtl/hash_loader_pkg.sv
// Shared definitions for the hash loader: command bytes, FSM states, hash geometry.
package hash_loader_pkg;

  localparam int unsigned HASH_W         = 128;
  localparam int unsigned BYTES_PER_HASH = 16;
  localparam int unsigned CNT_W          = 4;

  localparam logic [7:0] CMD_START = 8'hAA;
  localparam logic [7:0] CMD_CONT  = 8'h88;
  localparam logic [7:0] CMD_STOP  = 8'hEE;
  localparam logic [7:0] CMD_PROG  = 8'h6C;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StDelim,
    StDone
  } state_e;

  // Append one byte at the LSB end; earlier bytes move toward the MSB.
  function automatic logic [HASH_W-1:0] shift_in(input logic [HASH_W-1:0] h,
                                                 input logic [7:0]        b);
    return {h[HASH_W-9:0], b};
  endfunction

endpackage

// File: rtl/hash_loader_assembler.sv
// Byte-to-hash assembler: 128-bit shift-left-by-8 register plus a 4-bit byte counter.
// o_full flags that the next shifted byte completes the hash.
module hash_byte_assembler
  import hash_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_shift,
  input  logic              i_clear,
  input  logic [7:0]        i_byte,
  output logic [HASH_W-1:0] o_hash,
  output logic              o_full
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(BYTES_PER_HASH - 1);

  logic [HASH_W-1:0] r_hash;
  logic [CNT_W-1:0]  r_cnt;

  // Shift register and byte counter; clear has priority over shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hash <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_hash <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_hash <= shift_in(r_hash, i_byte);
      r_cnt  <= r_cnt + 1'b1;  // wraps to 0 after the 16th byte
    end
  end

  assign o_hash = r_hash;
  assign o_full = (r_cnt == LastIdx);

endmodule

// File: rtl/hash_loader.sv
// Host-command parser: decodes START/CONT/STOP/PROG from the UART byte stream, assembles
// 16-byte runs into 128-bit hashes and writes them to consecutive SRAM words.
// Optional receiver-error handling is enabled by defining HASH_LOADER_ERR_EN.
module hash_loader
  import hash_loader_pkg::*;
#(
  parameter int unsigned MAX_HASHES = 1024,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              data_ready,
  input  logic              framing_error,
  input  logic              overrun_error,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [HASH_W-1:0] write_data,
  output logic [ADDR_W:0]   hash_count,
  output logic              load_done,
  output logic              progress_req,
  output logic              load_err
);

  localparam logic [ADDR_W:0] MaxCnt = (ADDR_W + 1)'(MAX_HASHES);

  state_e            r_state, w_state_d;
  logic [ADDR_W:0]   r_count;
  logic              r_done;
  logic              r_err;
  logic              r_prog;
  logic [HASH_W-1:0] r_wdata;
  // A byte landing in the WRITE cycle is parked here and decoded in DELIM.
  logic              r_pend;
  logic [7:0]        r_pend_byte;
  logic              r_pend_fe;

  logic              w_vld, w_fe, w_cmd_vld;
  logic [7:0]        w_byte;
  logic              w_shift, w_clear, w_latch, w_inc, w_prog_d, w_done_set;
  logic              w_start, w_err_set, w_err_any, w_pend_set, w_pend_clr;
  logic [HASH_W-1:0] w_hash;
  logic              w_full;

  hash_byte_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .i_byte  (w_byte),
    .o_hash  (w_hash),
    .o_full  (w_full)
  );

  // Select the byte under decode: the parked byte wins in DELIM.
  always_comb begin
    w_vld  = data_ready;
    w_byte = rx_data;
    w_fe   = framing_error;
    if (r_state == StDelim && r_pend) begin
      w_vld  = 1'b1;
      w_byte = r_pend_byte;
      w_fe   = r_pend_fe;
    end
  end

`ifdef HASH_LOADER_ERR_EN
  assign w_cmd_vld = w_vld & ~w_fe;
  assign w_err_any = w_err_set | overrun_error;
`else
  logic w_unused_err;
  assign w_cmd_vld    = w_vld;
  assign w_err_any    = w_err_set;
  assign w_unused_err = framing_error ^ overrun_error ^ w_fe;
`endif

  // Next-state and control decode.
  always_comb begin
    w_state_d  = r_state;
    w_shift    = 1'b0;
    w_clear    = 1'b0;
    w_latch    = 1'b0;
    w_inc      = 1'b0;
    w_prog_d   = 1'b0;
    w_done_set = 1'b0;
    w_start    = 1'b0;
    w_err_set  = 1'b0;
    w_pend_set = 1'b0;
    w_pend_clr = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (w_cmd_vld) begin
          if (w_byte == CMD_START) begin
            w_start   = 1'b1;
            w_clear   = 1'b1;
            w_state_d = StCollect;
          end else if (w_byte == CMD_PROG) begin
            w_prog_d = 1'b1;
          end
        end
      end
      StCollect: begin
        if (w_vld) begin
`ifdef HASH_LOADER_ERR_EN
          if (w_fe) begin
            w_clear   = 1'b1;
            w_err_set = 1'b1;
            w_state_d = StDelim;
          end else
`endif
          begin
            w_shift = 1'b1;
            if (w_full) begin
              w_latch   = 1'b1;
              w_state_d = StWrite;
            end
          end
        end
      end
      StWrite: begin
        w_inc      = 1'b1;
        w_pend_set = data_ready;
        w_state_d  = StDelim;
      end
      StDelim: begin
        w_pend_clr = 1'b1;
        if (w_cmd_vld) begin
          if (w_byte == CMD_CONT) begin
            if (r_count == MaxCnt) begin
              // Table full: flag it and close the load as if STOP arrived.
              w_err_set  = 1'b1;
              w_done_set = 1'b1;
              w_state_d  = StDone;
            end else begin
              w_clear   = 1'b1;
              w_state_d = StCollect;
            end
          end else if (w_byte == CMD_STOP) begin
            w_done_set = 1'b1;
            w_state_d  = StDone;
          end else if (w_byte == CMD_PROG) begin
            w_prog_d = 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Hash count, status flags and the progress pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_prog  <= 1'b0;
    end else begin
      r_prog <= w_prog_d;
      if (w_start) r_count <= '0;
      else if (w_inc && r_count != MaxCnt) r_count <= r_count + 1'b1;
      if (w_start) r_done <= 1'b0;
      else if (w_done_set) r_done <= 1'b1;
      // An error in the same cycle as START still sticks.
      if (w_err_any) r_err <= 1'b1;
      else if (w_start) r_err <= 1'b0;
    end
  end

  // Write data is captured with the 16th byte and held until the next hash.
  always_ff @(posedge clk) begin
    if (rst) r_wdata <= '0;
    else if (w_latch) r_wdata <= shift_in(w_hash, w_byte);
  end

  // Park a byte that arrives during WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_pend_byte <= '0;
      r_pend_fe   <= 1'b0;
    end else if (w_pend_set) begin
      r_pend      <= 1'b1;
      r_pend_byte <= rx_data;
      r_pend_fe   <= framing_error;
    end else if (w_pend_clr) begin
      r_pend <= 1'b0;
    end
  end

  assign write_enable = (r_state == StWrite) && (r_count != MaxCnt);
  assign address      = r_count[ADDR_W-1:0];
  assign write_data   = r_wdata;
  assign hash_count   = r_count;
  assign load_done    = r_done;
  assign progress_req = r_prog;
  assign load_err     = r_err;

endmodule

// File: tb/tb_hash_loader.sv
// Self-checking bench for hash_loader: directed protocol cases plus a randomized byte stream
// checked every cycle against a byte-level protocol model.
module tb_hash_loader;

  localparam int MAXH = 2;
  localparam int AW   = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          data_ready = 1'b0;
  logic          framing_error = 1'b0;
  logic          overrun_error = 1'b0;
  logic          write_enable;
  logic [AW-1:0] address;
  logic [127:0]  write_data;
  logic [AW:0]   hash_count;
  logic          load_done;
  logic          progress_req;
  logic          load_err;

  hash_loader #(.MAX_HASHES(MAXH), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .write_enable  (write_enable),
    .address       (address),
    .write_data    (write_data),
    .hash_count    (hash_count),
    .load_done     (load_done),
    .progress_req  (progress_req),
    .load_err      (load_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SRAM stand-in, cleared through mem_clr.
  logic [127:0] mem [4];
  logic         mem_clr = 1'b0;
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 4; i++) mem[i] <= '0;
    else if (write_enable) mem[address[1:0]] <= write_data;
  end

  // ---------------- protocol model ----------------
  typedef enum int {MIdle, MCollect, MDelim, MDone} mst_e;
  mst_e         m_state = MIdle;
  logic [7:0]   m_buf[$];
  int           m_count = 0;
  bit           m_done = 0, m_err = 0;
  logic [127:0] m_wdata = '0;
  int           m_count_from = 0;
  int           exp_w_cyc[$];
  int           exp_w_addr[$];
  logic [127:0] exp_w_data[$];
  int           exp_p_cyc[$];

  // Apply one received byte; t is the first compare cycle that shows its effect.
  task automatic model_byte(input logic [7:0] b, input bit fe, input int t);
    bit fe_eff;
    logic [127:0] h;
`ifdef HASH_LOADER_ERR_EN
    fe_eff = fe;
`else
    fe_eff = 1'b0;
    if (fe) fe_eff = 1'b0;
`endif
    case (m_state)
      MIdle, MDone: begin
        if (!fe_eff && b == 8'hAA) begin
          m_count = 0; m_done = 0; m_err = 0; m_buf.delete();
          m_state = MCollect; m_count_from = t;
        end else if (!fe_eff && b == 8'h6C) begin
          exp_p_cyc.push_back(t);
        end
      end
      MCollect: begin
        if (fe_eff) begin
          m_err = 1; m_buf.delete(); m_state = MDelim;
        end else begin
          m_buf.push_back(b);
          if (m_buf.size() == 16) begin
            for (int i = 0; i < 16; i++) h[127-8*i -: 8] = m_buf[i];
            exp_w_cyc.push_back(t); exp_w_addr.push_back(m_count); exp_w_data.push_back(h);
            m_wdata = h; m_count++; m_count_from = t + 1;
            m_buf.delete(); m_state = MDelim;
          end
        end
      end
      MDelim: begin
        if (!fe_eff) begin
          if (b == 8'h88) begin
            if (m_count == MAXH) begin m_err = 1; m_done = 1; m_state = MDone; end
            else m_state = MCollect;
          end else if (b == 8'hEE) begin
            m_done = 1; m_state = MDone;
          end else if (b == 8'h6C) begin
            exp_p_cyc.push_back(t);
          end else begin
            m_err = 1;
          end
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- per-cycle compare ----------------
  int cyc = 0;
  bit chk_en = 0;
  int p_seen = 0, w_seen = 0;
  always @(negedge clk) begin
    cyc++;
    if (progress_req) p_seen++;
    if (write_enable) w_seen++;
    if (chk_en) begin
      while (exp_w_cyc.size() > 0 && exp_w_cyc[0] < cyc) begin
        chk("write_missed", 0, 1);
        void'(exp_w_cyc.pop_front()); void'(exp_w_addr.pop_front());
        void'(exp_w_data.pop_front());
      end
      while (exp_p_cyc.size() > 0 && exp_p_cyc[0] < cyc) begin
        chk("prog_missed", 0, 1);
        void'(exp_p_cyc.pop_front());
      end
      if (exp_w_cyc.size() > 0 && exp_w_cyc[0] == cyc) begin
        chk("write_enable", write_enable, 1);
        chk("write_addr", address, exp_w_addr[0]);
        chk("write_data", write_data, exp_w_data[0]);
        void'(exp_w_cyc.pop_front()); void'(exp_w_addr.pop_front());
        void'(exp_w_data.pop_front());
      end else begin
        chk("write_enable_idle", write_enable, 0);
      end
      if (exp_p_cyc.size() > 0 && exp_p_cyc[0] == cyc) begin
        chk("progress_req", progress_req, 1);
        void'(exp_p_cyc.pop_front());
      end else begin
        chk("progress_req_idle", progress_req, 0);
      end
      chk("load_done", load_done, m_done);
      chk("load_err", load_err, m_err);
      if (cyc >= m_count_from) begin
        chk("hash_count", hash_count, m_count);
        chk("address", address, m_count % (1 << AW));
        chk("write_data_hold", write_data, m_wdata);
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit fe = 0, input int gap = 0);
    @(posedge clk); #1;
    rx_data = b; data_ready = 1'b1; framing_error = fe;
    @(posedge clk);
    model_byte(b, fe, cyc + 1);
    #1;
    data_ready = 1'b0; framing_error = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_hash(input logic [127:0] h);
    for (int i = 0; i < 16; i++) send_byte(h[127-8*i -: 8]);
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(posedge clk); #1;
    rst = 1'b1; mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; mem_clr = 1'b0;
    m_state = MIdle; m_buf.delete(); m_count = 0; m_done = 0; m_err = 0;
    m_wdata = '0; m_count_from = 0;
    exp_w_cyc.delete(); exp_w_addr.delete(); exp_w_data.delete(); exp_p_cyc.delete();
    chk_en = 1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  localparam logic [127:0] H1 = 128'hE2E35A421944255FEB8EF91A141AC2D5;
  localparam logic [127:0] H2 = 128'h16958FECA9930E98CCD4E9376735A43A;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int p0, w0;
    logic [127:0] hx;
    logic [7:0] b;

    do_reset();
    settle(1);
    chk("rst_write_enable", write_enable, 0);
    chk("rst_progress_req", progress_req, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_hash_count", hash_count, 0);
    chk("rst_address", address, 0);
    chk("rst_write_data", write_data, 0);

    // Two-hash load.
    send_byte(8'hAA); send_hash(H1); send_byte(8'h88); send_hash(H2); send_byte(8'hEE);
    settle(2);
    chk("two_mem0", mem[0], 128'hE2E35A421944255FEB8EF91A141AC2D5);
    chk("two_mem1", mem[1], 128'h16958FECA9930E98CCD4E9376735A43A);
    chk("two_count", hash_count, 2);
    chk("two_done", load_done, 1);
    chk("two_err", load_err, 0);

    // Command value as hash data.
    do_reset();
    send_byte(8'hAA);
    for (int i = 0; i < 16; i++) send_byte(8'hEE);
    settle(2);
    chk("ee_done_early", load_done, 0);
    send_byte(8'hEE);
    settle(1);
    chk("ee_done", load_done, 1);
    chk("ee_mem0", mem[0], {16{8'hEE}});

    // Progress requests.
    do_reset();
    p0 = p_seen;
    send_byte(8'h6C);
    send_byte(8'hAA);
    for (int i = 0; i < 16; i++) send_byte((i == 3) ? 8'h6C : 8'(i));
    send_byte(8'h6C); send_byte(8'hEE); send_byte(8'h6C);
    settle(2);
    chk("prog_pulses", p_seen - p0, 3);

    // Full table.
    do_reset();
    w0 = w_seen;
    send_byte(8'hAA); send_hash(H1); send_byte(8'h88); send_hash(H2); send_byte(8'h88);
    settle(2);
    chk("full_writes", w_seen - w0, 2);
    chk("full_err", load_err, 1);
    chk("full_done", load_done, 1);
    chk("full_count", hash_count, 2);

    // Reset mid-hash.
    w0 = w_seen;
    send_byte(8'hAA);
    for (int i = 0; i < 7; i++) send_byte(8'h11);
    do_reset();
    chk("midrst_writes", w_seen - w0, 0);
    send_byte(8'hAA); send_hash(H2); send_byte(8'hEE);
    settle(2);
    chk("midrst_mem0", mem[0], H2);
    chk("midrst_count", hash_count, 1);

`ifdef HASH_LOADER_ERR_EN
    // Framing error on the 5th data byte.
    do_reset();
    w0 = w_seen;
    send_byte(8'hAA);
    for (int i = 0; i < 4; i++) send_byte(H1[127-8*i -: 8]);
    send_byte(8'h55, 1'b1);
    settle(2);
    chk("fe_writes", w_seen - w0, 0);
    chk("fe_err", load_err, 1);
    send_byte(8'h88); send_hash(H1);
    settle(2);
    chk("fe_mem0", mem[0], H1);
    chk("fe_count", hash_count, 1);
`endif

    // Randomized stream.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hAA;
        1: b = 8'h88;
        2: b = 8'hEE;
        3: b = 8'h6C;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_byte(b, ($urandom_range(0, 19) == 0), $urandom_range(0, 2));
      if ($urandom_range(0, 299) == 0) do_reset();
    end
    settle(3);
    chk("w_queue_drained", exp_w_cyc.size(), 0);
    chk("p_queue_drained", exp_p_cyc.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
